// File: rtl/avalon_s_rr_arbiter.sv
// N-host to 1-device Avalon-MM arbiter: round-robin with HOLD stickiness, grant locked across stalls.
// Define AVN_ARB_FIXED_PRIORITY_EN for lowest-index-wins selection (no last/hold tracking).
module avalon_s_rr_arbiter #(
  parameter int unsigned NH   = 2,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 32,
  parameter int unsigned HOLD = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NH-1:0]      hosts_avn_read,
  input  logic [NH-1:0]      hosts_avn_write,
  input  logic [NH*AW-1:0]   hosts_avn_address,
  input  logic [NH*DW/8-1:0] hosts_avn_byte_enable,
  input  logic [NH*DW-1:0]   hosts_avn_writedata,
  output logic [NH*DW-1:0]   hosts_avn_readdata,
  output logic [NH-1:0]      hosts_avn_waitrequest,
  output logic               device_avn_read,
  output logic               device_avn_write,
  output logic [AW-1:0]      device_avn_address,
  output logic [DW/8-1:0]    device_avn_byte_enable,
  output logic [DW-1:0]      device_avn_writedata,
  input  logic [DW-1:0]      device_avn_readdata,
  input  logic               device_avn_waitrequest
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned LW = (NH > 1) ? $clog2(NH) : 1;

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e        r_state;
  logic [NH-1:0] r_grant;
  logic [NH-1:0] w_req;
  logic [NH-1:0] w_win;
  logic [NH-1:0] w_grant;
  logic          w_active;

  assign w_req = hosts_avn_read | hosts_avn_write;

`ifdef AVN_ARB_FIXED_PRIORITY_EN
  always_comb begin
    logic found;
    w_win = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NH); i++) begin
      if (w_req[i] && !found) begin
        w_win[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  localparam int unsigned CW = $clog2(HOLD + 1);

  logic [LW-1:0] r_last;
  logic [CW-1:0] r_hold;
  logic [LW-1:0] w_gnt_idx;
  logic          w_done;

  // r_hold == 0 means nothing has completed since reset, so no stickiness applies.
  always_comb begin
    logic          found;
    int unsigned   j;
    logic [LW-1:0] idx;
    w_win = '0;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    if (r_hold != '0 && r_hold < CW'(HOLD) && w_req[r_last]) begin
      w_win[r_last] = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NH; k++) begin
        j = int'(r_last) + k;
        if (j >= NH) j = j - NH;
        idx = LW'(j);
        if (w_req[idx] && !found) begin
          w_win[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < int'(NH); i++) begin
      if (w_grant[i]) w_gnt_idx = LW'(i);
    end
  end

  assign w_done = w_active & ~device_avn_waitrequest;
`endif

  assign w_grant  = (r_state == StLock) ? r_grant : w_win;
  assign w_active = |(w_grant & w_req);

  // AND-OR mux keeps ungranted lanes from leaking X into the device command.
  always_comb begin
    device_avn_read        = |(w_grant & hosts_avn_read);
    device_avn_write       = |(w_grant & hosts_avn_write);
    device_avn_address     = '0;
    device_avn_byte_enable = '0;
    device_avn_writedata   = '0;
    for (int i = 0; i < int'(NH); i++) begin
      device_avn_address     = device_avn_address |
                               (hosts_avn_address[i*AW +: AW] & {AW{w_grant[i]}});
      device_avn_byte_enable = device_avn_byte_enable |
                               (hosts_avn_byte_enable[i*BW +: BW] & {BW{w_grant[i]}});
      device_avn_writedata   = device_avn_writedata |
                               (hosts_avn_writedata[i*DW +: DW] & {DW{w_grant[i]}});
    end
  end

  assign hosts_avn_waitrequest = ~w_grant | {NH{device_avn_waitrequest}};
  assign hosts_avn_readdata    = {NH{device_avn_readdata}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_grant <= '0;
`ifndef AVN_ARB_FIXED_PRIORITY_EN
      r_last  <= LW'(NH - 1);
      r_hold  <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_active && device_avn_waitrequest) begin
            r_grant <= w_grant;
            r_state <= StLock;
          end
        end
        StLock: begin
          // Either a completion or the granted host abandoning its request.
          if (!w_active || !device_avn_waitrequest) begin
            r_grant <= '0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
`ifndef AVN_ARB_FIXED_PRIORITY_EN
      if (w_done) begin
        r_last <= w_gnt_idx;
        if (w_gnt_idx == r_last) begin
          if (r_hold < CW'(HOLD)) r_hold <= r_hold + 1'b1;
        end else begin
          r_hold <= CW'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_avalon_s_rr_arbiter.sv
// Scoreboard bench for avalon_s_rr_arbiter: two NH=4 instances (HOLD=1 and HOLD=3) on shared stimulus.
module tb_avalon_s_rr_arbiter;
  localparam int unsigned NH = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = DW / 8;

  localparam int KAddr  = 0;
  localparam int KRd    = 1;
  localparam int KWr    = 2;
  localparam int KWdata = 3;
  localparam int KBe    = 4;
  localparam int KWait  = 5;
  localparam int KRdat1 = 6;
  localparam int KAddrB = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic [NH-1:0] rd, wr;
  logic [AW-1:0] addr  [NH];
  logic [DW-1:0] wdata [NH];
  logic [NH*AW-1:0] addr_flat;
  logic [NH*BW-1:0] be_flat;
  logic [NH*DW-1:0] wdata_flat;
  logic dev_wait;
  logic [DW-1:0] dev_rdata;

  logic [NH*DW-1:0] a_rdata, b_rdata;
  logic [NH-1:0]    a_wait, b_wait;
  logic             a_rd, a_wr, b_rd, b_wr;
  logic [AW-1:0]    a_addr, b_addr;
  logic [BW-1:0]    a_be, b_be;
  logic [DW-1:0]    a_wdata, b_wdata;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(NH); i++) begin
      addr_flat[i*AW +: AW]  = addr[i];
      be_flat[i*BW +: BW]    = BW'(i + 1);
      wdata_flat[i*DW +: DW] = wdata[i];
    end
  end

  avalon_s_rr_arbiter #(.NH(NH), .DW(DW), .AW(AW), .HOLD(1)) u_dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .hosts_avn_read         (rd),
    .hosts_avn_write        (wr),
    .hosts_avn_address      (addr_flat),
    .hosts_avn_byte_enable  (be_flat),
    .hosts_avn_writedata    (wdata_flat),
    .hosts_avn_readdata     (a_rdata),
    .hosts_avn_waitrequest  (a_wait),
    .device_avn_read        (a_rd),
    .device_avn_write       (a_wr),
    .device_avn_address     (a_addr),
    .device_avn_byte_enable (a_be),
    .device_avn_writedata   (a_wdata),
    .device_avn_readdata    (dev_rdata),
    .device_avn_waitrequest (dev_wait)
  );

  avalon_s_rr_arbiter #(.NH(NH), .DW(DW), .AW(AW), .HOLD(3)) u_dut_h3 (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .hosts_avn_read         (rd),
    .hosts_avn_write        (wr),
    .hosts_avn_address      (addr_flat),
    .hosts_avn_byte_enable  (be_flat),
    .hosts_avn_writedata    (wdata_flat),
    .hosts_avn_readdata     (b_rdata),
    .hosts_avn_waitrequest  (b_wait),
    .device_avn_read        (b_rd),
    .device_avn_write       (b_wr),
    .device_avn_address     (b_addr),
    .device_avn_byte_enable (b_be),
    .device_avn_writedata   (b_wdata),
    .device_avn_readdata    (dev_rdata),
    .device_avn_waitrequest (dev_wait)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] observe(input int kind);
    case (kind)
      KAddr:   return 64'(a_addr);
      KRd:     return 64'(a_rd);
      KWr:     return 64'(a_wr);
      KWdata:  return 64'(a_wdata);
      KBe:     return 64'(a_be);
      KWait:   return 64'(a_wait);
      KRdat1:  return 64'(a_rdata[1*DW +: DW]);
      KAddrB:  return 64'(b_addr);
      default: return '1;
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [63:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle on the falling edge, then move past the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.kind), e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NH-1:0] r, input logic [NH-1:0] w, input logic wt);
    rd       = r;
    wr       = w;
    dev_wait = wt;
  endtask

  function automatic logic [63:0] host_addr(input int h);
    return 64'(32'h1000 + 32'(h) * 32'h100);
  endfunction

  int rot_a[6], rot_b[6], stk_a[7], stk_b[7], post_a[3];

  initial begin
`ifdef AVN_ARB_FIXED_PRIORITY_EN
    rot_a  = '{0, 0, 0, 0, 0, 0};
    rot_b  = '{0, 0, 0, 0, 0, 0};
    stk_a  = '{0, 0, 0, 0, 0, 0, 0};
    stk_b  = '{0, 0, 0, 0, 0, 0, 0};
    post_a = '{1, 1, 1};
`else
    rot_a  = '{0, 1, 2, 3, 0, 1};
    rot_b  = '{0, 0, 0, 1, 1, 1};
    stk_a  = '{0, 2, 0, 2, 0, 2, 0};
    stk_b  = '{0, 0, 0, 2, 2, 2, 0};
    post_a = '{1, 2, 3};
`endif
    rd = '0; wr = '0; dev_wait = 1'b1; dev_rdata = '0; rst_n = 1'b0;
    for (int i = 0; i < int'(NH); i++) begin
      addr[i]  = host_addr(i)[AW-1:0];
      wdata[i] = 32'hA5A5_0000 | 32'(i);
    end
    #1;

    push("rst_rd", KRd, 64'h0);
    push("rst_wr", KWr, 64'h0);
    push("rst_addr", KAddr, 64'h0);
    push("rst_wait", KWait, 64'hF);
    cycle();
    rst_n = 1'b1;

    // Single read by host1, stalled three cycles.
    addr[1] = 32'h100;
    drive(4'b0010, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      push("rd_addr", KAddr, 64'h100);
      push("rd_cmd", KRd, 64'h1);
      push("rd_wait_stall", KWait, 64'hF);
      cycle();
    end
    dev_wait  = 1'b0;
    dev_rdata = 32'hDEAD_BEEF;
    push("rd_addr_done", KAddr, 64'h100);
    push("rd_wait_done", KWait, 64'hD);
    push("rd_data", KRdat1, 64'hDEAD_BEEF);
    cycle();
    addr[1] = host_addr(1)[AW-1:0];
    drive(4'b0000, 4'b0000, 1'b1);
    push("idle_rd", KRd, 64'h0);
    push("idle_addr", KAddr, 64'h0);
    cycle();

    // Host3 write locked while host2 (ahead in rotation) requests.
    drive(4'b0000, 4'b1000, 1'b1);
    push("lk_addr", KAddr, host_addr(3));
    push("lk_wr", KWr, 64'h1);
    push("lk_wdata", KWdata, 64'hA5A5_0003);
    push("lk_be", KBe, 64'h4);
    push("lk_wait", KWait, 64'hF);
    cycle();
    drive(4'b0100, 4'b1000, 1'b1);
    push("lk_hold_addr", KAddr, host_addr(3));
    push("lk_hold_rd", KRd, 64'h0);
    push("lk_hold_wr", KWr, 64'h1);
    cycle();
    dev_wait = 1'b0;
    push("lk_done_addr", KAddr, host_addr(3));
    push("lk_done_wait", KWait, 64'h7);
    cycle();
    drive(4'b0100, 4'b0000, 1'b1);
    push("lk_next_addr", KAddr, host_addr(2));
    push("lk_next_rd", KRd, 64'h1);
    push("lk_next_wr", KWr, 64'h0);
    cycle();
    dev_wait = 1'b0;
    push("lk_next_wait", KWait, 64'hB);
    cycle();

    // Rotation: all hosts, no stalls.
    drive(4'b0000, 4'b0000, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      push("rot_h1", KAddr, host_addr(rot_a[k]));
      push("rot_h3", KAddrB, host_addr(rot_b[k]));
      cycle();
    end

    // Stickiness: hosts 0 and 2.
    drive(4'b0000, 4'b0000, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(4'b0101, 4'b0000, 1'b0);
    for (int k = 0; k < 7; k++) begin
      push("stk_h1", KAddr, host_addr(stk_a[k]));
      push("stk_h3", KAddrB, host_addr(stk_b[k]));
      cycle();
    end
    drive(4'b0000, 4'b0000, 1'b1);
    cycle();

    // Reset asserted mid-lock on host2.
    drive(4'b0000, 4'b0100, 1'b1);
    push("rl_addr", KAddr, host_addr(2));
    cycle();
    drive(4'b1010, 4'b0100, 1'b1);
    push("rl_hold_addr", KAddr, host_addr(2));
    cycle();
    #2;
    rst_n = 1'b0;
    push("rl_rst_h1", KAddr, host_addr(1));
    push("rl_rst_h3", KAddrB, host_addr(1));
    cycle();
    rst_n    = 1'b1;
    dev_wait = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push("rl_post_h1", KAddr, host_addr(post_a[k]));
      push("rl_post_h3", KAddrB, host_addr(1));
      cycle();
    end
    drive(4'b0000, 4'b0000, 1'b1);
    cycle();

    // Granted host abandons its request while locked.
    drive(4'b0001, 4'b0000, 1'b1);
    push("pv_addr", KAddr, host_addr(0));
    push("pv_rd", KRd, 64'h1);
    cycle();
    drive(4'b0010, 4'b0000, 1'b1);
    push("pv_drop_addr", KAddr, host_addr(0));
    push("pv_drop_rd", KRd, 64'h0);
    push("pv_drop_wait", KWait, 64'hF);
    cycle();
    push("pv_next_addr", KAddr, host_addr(1));
    push("pv_next_rd", KRd, 64'h1);
    cycle();
    dev_wait = 1'b0;
    push("pv_next_wait", KWait, 64'hD);
    cycle();
    drive(4'b0000, 4'b0000, 1'b1);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
